// File: rtl/jtpang_chr_fetch_if.sv
// Signal bundle between the char-layer fetcher and its neighbours:
// the line timing, the char VRAM, the char ROM slot and the line buffer.
interface jtpang_chr_fetch_if;
    logic        line_start;
    logic [7:0]  vrender;
    logic        busy;
    logic [10:0] vram_addr;
    logic [13:0] vram_code;
    logic [7:0]  vram_attr;
    // ROM handshake: chr_cs is held with a stable chr_addr until chr_ok is
    // taken; chr_ok is only trusted from the second cycle of a request.
    logic        chr_cs;
    logic [16:0] chr_addr;
    logic [31:0] chr_data;
    logic        chr_ok;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;

    modport master (
        input  line_start, vrender, vram_code, vram_attr, chr_data, chr_ok,
        output busy, vram_addr, chr_cs, chr_addr, buf_we, buf_addr, buf_din
    );

    modport slave (
        output line_start, vrender, vram_code, vram_attr, chr_data, chr_ok,
        input  busy, vram_addr, chr_cs, chr_addr, buf_we, buf_addr, buf_din
    );
endinterface

// File: rtl/jtpang_chr_fetch.sv
// JTPANG char-layer scanline fetcher: walks one map row, fetches each tile
// row from the char ROM and writes 8 palette-tagged pixels per tile.
module jtpang_chr_fetch #(
    parameter int TILES = 48
) (
    input  logic                      clk,
    input  logic                      rst_n,
    jtpang_chr_fetch_if.master        bus,
    output logic [2:0]                st_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VRAM  = 3'd1,
        LATCH = 3'd2,
        WAIT  = 3'd3,
        DRAW  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_COL = 6'(TILES - 1);

    state_t      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  vr_q, vr_d;
    logic [3:0]  pal_q, pal_d;
    logic        hflip_q, hflip_d;
    logic [31:0] pix_q, pix_d;
    logic        wait2_q, wait2_d;
    logic        busy_q, busy_d;
    logic [10:0] vram_addr_q, vram_addr_d;
    logic        chr_cs_q, chr_cs_d;
    logic [16:0] chr_addr_q, chr_addr_d;
    logic        buf_we_q, buf_we_d;
    logic [8:0]  buf_addr_q, buf_addr_d;
    logic [7:0]  buf_din_q, buf_din_d;

    // Pixel n sits in nibble 7-n counting from the LSB; hflip reverses that.
    function automatic logic [3:0] nibble(input logic [31:0] d, input logic [2:0] n,
                                          input logic flip);
        logic [2:0] idx;
        idx = flip ? n : (3'd7 - n);
        return d[{idx, 2'b00} +: 4];
    endfunction

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        n_d         = n_q;
        vr_d        = vr_q;
        pal_d       = pal_q;
        hflip_d     = hflip_q;
        pix_d       = pix_q;
        wait2_d     = wait2_q;
        busy_d      = busy_q;
        vram_addr_d = vram_addr_q;
        chr_cs_d    = chr_cs_q;
        chr_addr_d  = chr_addr_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_din_d   = buf_din_q;

        if (bus.line_start) begin
            // Start or abort-and-restart look the same from here on.
            state_d     = VRAM;
            vr_d        = bus.vrender;
            col_d       = 6'd0;
            busy_d      = 1'b1;
            vram_addr_d = {bus.vrender[7:3], 6'd0};
            chr_cs_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: busy_d = 1'b0;
                VRAM: state_d = LATCH;
                LATCH: begin
                    pal_d      = bus.vram_attr[3:0];
                    hflip_d    = bus.vram_attr[7];
                    chr_addr_d = {bus.vram_code, vr_q[2:0]};
                    chr_cs_d   = 1'b1;
                    wait2_d    = 1'b0;
                    state_d    = WAIT;
                end
                WAIT: begin
                    if (!wait2_q) begin
                        wait2_d = 1'b1;
                    end else if (bus.chr_ok) begin
                        pix_d      = bus.chr_data;
                        chr_cs_d   = 1'b0;
                        n_d        = 3'd0;
                        buf_we_d   = 1'b1;
                        buf_addr_d = {col_q, 3'd0};
                        buf_din_d  = {pal_q, nibble(bus.chr_data, 3'd0, hflip_q)};
                        state_d    = DRAW;
                    end
                end
                DRAW: begin
                    if (n_q != 3'd7) begin
                        n_d        = n_q + 3'd1;
                        buf_we_d   = 1'b1;
                        buf_addr_d = {col_q, n_d};
                        buf_din_d  = {pal_q, nibble(pix_q, n_d, hflip_q)};
                    end else if (col_q == LAST_COL) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        col_d       = col_q + 6'd1;
                        vram_addr_d = {vr_q[7:3], col_d};
                        state_d     = VRAM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 6'd0;
            n_q         <= 3'd0;
            vr_q        <= 8'd0;
            pal_q       <= 4'd0;
            hflip_q     <= 1'b0;
            pix_q       <= 32'd0;
            wait2_q     <= 1'b0;
            busy_q      <= 1'b0;
            vram_addr_q <= 11'd0;
            chr_cs_q    <= 1'b0;
            chr_addr_q  <= 17'd0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= 9'd0;
            buf_din_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            n_q         <= n_d;
            vr_q        <= vr_d;
            pal_q       <= pal_d;
            hflip_q     <= hflip_d;
            pix_q       <= pix_d;
            wait2_q     <= wait2_d;
            busy_q      <= busy_d;
            vram_addr_q <= vram_addr_d;
            chr_cs_q    <= chr_cs_d;
            chr_addr_q  <= chr_addr_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_din_q   <= buf_din_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.vram_addr = vram_addr_q;
    assign bus.chr_cs    = chr_cs_q;
    assign bus.chr_addr  = chr_addr_q;
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_din   = buf_din_q;
    assign st_dbg        = state_q;

endmodule
